// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter (inhibit, request,
//            device-clocked serial shift, ACK check, bus-idle wait).
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int PACKET_TIMEOUT = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send_valid,
    input  logic [7:0] send_data,
    output logic       send_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int c_T_MAX   = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
    localparam int c_CNT_TOP = (c_T_MAX > INHIBIT_CYCLES) ? c_T_MAX : INHIBIT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_TOP + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_INHIBIT    = c_CNT_W'(INHIBIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_INH_LAST   = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_PKT_LIMIT  = c_CNT_W'(PACKET_TIMEOUT);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_INHIBIT   = 3'd1;
    localparam logic [2:0] c_S_REQ       = 3'd2;
    localparam logic [2:0] c_S_XFER      = 3'd3;
    localparam logic [2:0] c_S_ACK       = 3'd4;
    localparam logic [2:0] c_S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] c_S_FINISH    = 3'd6;

    logic [2:0]         r_state;
    logic [1:0]         r_clk_sync;
    logic [1:0]         r_dat_sync;
    logic               r_clk_prev;
    logic [7:0]         r_data;
    logic               r_parity;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] r_pkt_cnt;
    logic [3:0]         r_edge_cnt;
    logic               r_clk_oe;
    logic               r_dat_oe;
    logic               r_done;
    logic               r_error;

    logic               w_fall;
    logic               w_pkt_expired;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [c_CNT_W-1:0] w_pkt_inc;

    assign w_fall        = r_clk_prev & ~r_clk_sync[1];
    assign w_pkt_expired = (r_pkt_cnt >= c_PKT_LIMIT);
    assign w_cnt_inc     = (r_cnt == '1) ? r_cnt : r_cnt + c_CNT_ONE;
    assign w_pkt_inc     = (r_pkt_cnt == '1) ? r_pkt_cnt : r_pkt_cnt + c_CNT_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
            r_data     <= '0;
            r_parity   <= 1'b0;
            r_cnt      <= '0;
            r_pkt_cnt  <= '0;
            r_edge_cnt <= '0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
            r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
            r_clk_prev <= r_clk_sync[1];
            r_done     <= 1'b0;
            r_error    <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    if (send_valid) begin
                        r_data     <= send_data;
                        r_parity   <= ~^send_data;
                        r_cnt      <= '0;
                        r_pkt_cnt  <= '0;
                        r_edge_cnt <= '0;
                        r_clk_oe   <= 1'b1;
                        r_state    <= c_S_INHIBIT;
                    end
                end

                c_S_INHIBIT: begin
                    if (r_cnt >= c_INHIBIT) begin
                        r_clk_oe <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= c_S_REQ;
                    end else begin
                        // last inhibit cycle: drop DAT for the start bit while CLK is still held
                        if (r_cnt == c_INH_LAST) begin
                            r_dat_oe <= 1'b1;
                        end
                        r_cnt <= w_cnt_inc;
                    end
                end

                c_S_REQ: begin
                    if (w_fall) begin
                        r_dat_oe   <= ~r_data[0];
                        r_edge_cnt <= 4'd1;
                        r_pkt_cnt  <= '0;
                        r_state    <= c_S_XFER;
                    end else if (r_cnt >= c_START_LAST) begin
                        r_dat_oe <= 1'b0;
                        r_error  <= 1'b1;
                        r_state  <= c_S_FINISH;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                c_S_XFER: begin
                    r_pkt_cnt <= w_pkt_inc;
                    if (w_pkt_expired) begin
                        r_dat_oe <= 1'b0;
                        r_error  <= 1'b1;
                        r_state  <= c_S_FINISH;
                    end else if (w_fall) begin
                        // r_edge_cnt holds the number of falling edges already seen
                        r_edge_cnt <= r_edge_cnt + 4'd1;
                        if (r_edge_cnt <= 4'd7) begin
                            r_dat_oe <= ~r_data[r_edge_cnt[2:0]];
                        end else if (r_edge_cnt == 4'd8) begin
                            r_dat_oe <= ~r_parity;
                        end else if (r_edge_cnt == 4'd9) begin
                            r_dat_oe <= 1'b0;
                        end else begin
                            r_state <= c_S_ACK;
                        end
                    end
                end

                c_S_ACK: begin
                    r_pkt_cnt <= w_pkt_inc;
                    r_dat_oe  <= 1'b0;
                    if (!w_pkt_expired && !r_dat_sync[1]) begin
                        r_state <= c_S_WAIT_IDLE;
                    end else begin
                        r_error <= 1'b1;
                        r_state <= c_S_FINISH;
                    end
                end

                c_S_WAIT_IDLE: begin
                    r_pkt_cnt <= w_pkt_inc;
                    if (w_pkt_expired) begin
                        r_error <= 1'b1;
                        r_state <= c_S_FINISH;
                    end else if (r_clk_sync[1] && r_dat_sync[1]) begin
                        r_done  <= 1'b1;
                        r_state <= c_S_FINISH;
                    end
                end

                c_S_FINISH: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_state  <= c_S_IDLE;
                end

                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_state  <= c_S_IDLE;
                end
            endcase
        end
    end

    assign send_ready = (r_state == c_S_IDLE);
    assign busy       = ~send_ready;
    assign done       = r_done;
    assign error      = r_error;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

endmodule
`default_nettype wire
